// File: rtl/keypad_entry.sv
// Debounced 8-key keypad front end: synchronizes raw buttons, qualifies single
// presses into a 3-bit digit pulse, flags multi-key presses and abandons stale entries.
module keypad_entry #(
  parameter int DB_CYCLES    = 4,
  parameter int IDLE_TIMEOUT = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keys,
  output logic [2:0] key,
  output logic       key_valid,
  output logic       multi_err,
  output logic       entry_timeout,
  output logic [1:0] digit_count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, WAIT_REL, REL_DB} state_t;

  localparam logic [7:0]  DB_LAST = 8'(DB_CYCLES - 1);
  localparam logic [15:0] TO_LAST = 16'(IDLE_TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  sync1_q;
  logic [7:0]  keys_s_q;
  logic [7:0]  snap_q;
  logic [7:0]  db_cnt_q;
  logic [15:0] idle_cnt_q;
  logic [2:0]  key_q;
  logic        key_valid_q;
  logic        multi_err_q;
  logic        entry_timeout_q;
  logic [1:0]  digit_count_q;

  logic        snap_onehot_d;
  logic [2:0]  snap_idx_d;

  always_comb begin
    snap_onehot_d = (snap_q != 8'd0) && ((snap_q & (snap_q - 8'd1)) == 8'd0);
    snap_idx_d    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (snap_q[i]) snap_idx_d = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      sync1_q         <= 8'd0;
      keys_s_q        <= 8'd0;
      snap_q          <= 8'd0;
      db_cnt_q        <= 8'd0;
      idle_cnt_q      <= 16'd0;
      key_q           <= 3'd0;
      key_valid_q     <= 1'b0;
      multi_err_q     <= 1'b0;
      entry_timeout_q <= 1'b0;
      digit_count_q   <= 2'd0;
    end else begin
      sync1_q         <= keys;
      keys_s_q        <= sync1_q;
      key_valid_q     <= 1'b0;
      multi_err_q     <= 1'b0;
      entry_timeout_q <= 1'b0;

      case (state_q)
        IDLE: begin
          // A press leaving IDLE takes priority over a timeout on the same edge.
          if (keys_s_q != 8'd0) begin
            snap_q     <= keys_s_q;
            db_cnt_q   <= 8'd0;
            idle_cnt_q <= 16'd0;
            state_q    <= PRESS_DB;
          end else if (digit_count_q == 2'd0) begin
            idle_cnt_q <= 16'd0;
          end else if (idle_cnt_q == TO_LAST) begin
            entry_timeout_q <= 1'b1;
            digit_count_q   <= 2'd0;
            idle_cnt_q      <= 16'd0;
          end else begin
            idle_cnt_q <= idle_cnt_q + 16'd1;
          end
        end

        PRESS_DB: begin
          if (keys_s_q != snap_q) begin
            state_q <= IDLE;
          end else if (db_cnt_q == DB_LAST) begin
            state_q <= WAIT_REL;
            if (snap_onehot_d) begin
              key_q         <= snap_idx_d;
              key_valid_q   <= 1'b1;
              digit_count_q <= digit_count_q + 2'd1;
            end else begin
              multi_err_q <= 1'b1;
            end
          end else begin
            db_cnt_q <= db_cnt_q + 8'd1;
          end
        end

        WAIT_REL: begin
          if (keys_s_q == 8'd0) begin
            db_cnt_q <= 8'd0;
            state_q  <= REL_DB;
          end
        end

        REL_DB: begin
          if (keys_s_q != 8'd0) begin
            state_q <= WAIT_REL;
          end else if (db_cnt_q == DB_LAST) begin
            state_q <= IDLE;
          end else begin
            db_cnt_q <= db_cnt_q + 8'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign key           = key_q;
  assign key_valid     = key_valid_q;
  assign multi_err     = multi_err_q;
  assign entry_timeout = entry_timeout_q;
  assign digit_count   = digit_count_q;
  assign busy          = (state_q != IDLE);

endmodule
